// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Sequences the PLL's RESETB/LOCK handshake from the 12 MHz
//            reference clock. Holds the PLL in reset, waits for a
//            synchronized lock, requires lock to stay stable, then releases
//            the PLL-domain system reset. Re-arms the PLL after a lock
//            timeout or a lock loss, and counts both events (saturating).
// Ports    : clock_in      - reference clock, rising edge
//            reset_n       - asynchronous active-low reset
//            locked        - PLL LOCK, asynchronous to clock_in
//            restart       - synchronous single-cycle re-sequence request
//            pll_resetb    - PLL RESETB (low = PLL held in reset)
//            sys_reset_n   - active-low reset for PLL-domain consumers
//            ready         - high only while running with stable lock
//            timeout_count - saturating count of lock timeouts
//            loss_count    - saturating count of lock losses while running
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
  parameter int RESETB_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic [7:0] timeout_count,
  output logic [7:0] loss_count
);

  // Terminal counts of the phase counter; each cycle parameter is at most
  // 2^CNT_W, so the value minus one always fits in CNT_W bits.
  localparam logic [CNT_W-1:0] c_resetb_last = CNT_W'(RESETB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Two-flop synchronizer for the asynchronous lock flag.
  logic             sync1_q;
  logic             locked_s_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             ready_q, ready_d;
  logic [7:0]       timeout_count_q, timeout_count_d;
  logic [7:0]       loss_count_q, loss_count_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    timeout_count_d = timeout_count_q;
    loss_count_d    = loss_count_q;

    // restart overrides every other transition and suppresses both counters;
    // in RESET_PLL it re-clears cnt, stretching the PLL reset.
    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == c_resetb_last) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so a lock on the last cycle is not a timeout.
          if (locked_s_q) begin
            state_d = STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == c_timeout_last) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
          end
        end
        STABILIZE: begin
          if (!locked_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == c_stable_last) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          // cnt is free-running here and has no meaning.
          if (!locked_s_q) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            if (loss_count_q != 8'hFF) loss_count_d = loss_count_q + 8'd1;
          end
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registered outputs
    // change on the same edge as the state register.
    pll_resetb_d  = (state_d != RESET_PLL);
    sys_reset_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q         <= 1'b0;
      locked_s_q      <= 1'b0;
      state_q         <= RESET_PLL;
      cnt_q           <= '0;
      pll_resetb_q    <= 1'b0;
      sys_reset_n_q   <= 1'b0;
      ready_q         <= 1'b0;
      timeout_count_q <= 8'd0;
      loss_count_q    <= 8'd0;
    end else begin
      sync1_q         <= locked;
      locked_s_q      <= sync1_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pll_resetb_q    <= pll_resetb_d;
      sys_reset_n_q   <= sys_reset_n_d;
      ready_q         <= ready_d;
      timeout_count_q <= timeout_count_d;
      loss_count_q    <= loss_count_d;
    end
  end

  assign pll_resetb    = pll_resetb_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign ready         = ready_q;
  assign timeout_count = timeout_count_q;
  assign loss_count    = loss_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Purpose  : Directed self-checking bench for pll_lock_sequencer with
//            RESETB_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic [7:0] timeout_count;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  pll_lock_sequencer #(
    .RESETB_CYCLES(4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .CNT_W        (16)
  ) u_dut (
    .clock_in     (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .restart      (restart),
    .pll_resetb   (pll_resetb),
    .sys_reset_n  (sys_reset_n),
    .ready        (ready),
    .timeout_count(timeout_count),
    .loss_count   (loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    #1 reset_n = 1'b0;
    tick(3);

    // Reset state
    chk("rst_pll_resetb", pll_resetb, 0);
    chk("rst_sys_reset_n", sys_reset_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_timeout", timeout_count, 0);
    chk("rst_loss", loss_count, 0);

    // Cold start: pll_resetb up on 4th edge, lock 10 edges after release
    reset_n = 1'b1;
    tick(3);
    chk("cold_pll_low_e3", pll_resetb, 0);
    tick(1);
    chk("cold_pll_high_e4", pll_resetb, 1);
    tick(6);
    locked = 1'b1;
    tick(10);
    chk("cold_sys_low_e10", sys_reset_n, 0);
    chk("cold_ready_low_e10", ready, 0);
    tick(1);
    chk("cold_sys_high_e11", sys_reset_n, 1);
    chk("cold_ready_high_e11", ready, 1);
    chk("cold_timeout", timeout_count, 0);
    chk("cold_loss", loss_count, 0);

    // Lock loss in RUN: reaction 3 edges after locked falls
    locked = 1'b0;
    tick(2);
    chk("loss_sys_high_e2", sys_reset_n, 1);
    chk("loss_count_e2", loss_count, 0);
    tick(1);
    chk("loss_sys_low_e3", sys_reset_n, 0);
    chk("loss_pll_low_e3", pll_resetb, 0);
    chk("loss_ready_low_e3", ready, 0);
    chk("loss_count_e3", loss_count, 1);
    // Recovery repeats cold-start timing
    tick(3);
    chk("rec_pll_low", pll_resetb, 0);
    tick(1);
    chk("rec_pll_high", pll_resetb, 1);
    locked = 1'b1;
    tick(10);
    chk("rec_sys_low", sys_reset_n, 0);
    tick(1);
    chk("rec_sys_high", sys_reset_n, 1);

    // Restart coinciding with locked_s falling in RUN: no loss increment
    locked = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("simul_sys_low", sys_reset_n, 0);
    chk("simul_pll_low", pll_resetb, 0);
    chk("simul_loss", loss_count, 1);

    // Stabilize glitch: STABILIZE entered 5 edges after restart (S)
    locked = 1'b1;
    tick(4);
    chk("glitch_pll_high", pll_resetb, 1);
    tick(6);                       // S+5
    locked = 1'b0;
    tick(1);                       // S+6
    locked = 1'b1;
    tick(2);                       // S+8: would have released without glitch
    chk("glitch_no_release", ready, 0);
    tick(8);                       // S+16
    chk("glitch_ready_low_s16", ready, 0);
    tick(1);                       // S+17
    chk("glitch_ready_high_s17", ready, 1);
    chk("glitch_sys_high_s17", sys_reset_n, 1);
    chk("glitch_loss", loss_count, 1);
    chk("glitch_timeout", timeout_count, 0);

    // Lock arriving on WAIT_LOCK cnt=31 beats the timeout
    locked  = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(4);                       // E0: WAIT_LOCK entry
    chk("prio_pll_high_e0", pll_resetb, 1);
    tick(29);
    locked = 1'b1;
    tick(3);                       // E0+32
    chk("prio_pll_high_e32", pll_resetb, 1);
    chk("prio_timeout", timeout_count, 0);
    tick(8);
    chk("prio_ready", ready, 1);

    // Two more lock losses to reach loss_count=3
    for (int i = 2; i <= 3; i++) begin
      locked = 1'b0;
      tick(3);
      chk("loop_loss_count", loss_count, i);
      chk("loop_sys_low", sys_reset_n, 0);
      locked = 1'b1;
      tick(13);
      chk("loop_ready", ready, 1);
    end

    // Async reset mid-RUN, partial cycle
    reset_n = 1'b0;
    #1;
    chk("arst_pll_resetb", pll_resetb, 0);
    chk("arst_sys_reset_n", sys_reset_n, 0);
    chk("arst_ready", ready, 0);
    chk("arst_loss", loss_count, 0);
    chk("arst_timeout", timeout_count, 0);
    reset_n = 1'b1;
    tick(3);
    chk("arst_rel_pll_low", pll_resetb, 0);
    tick(1);
    chk("arst_rel_pll_high", pll_resetb, 1);

    // Timeout: locked held low, 36-cycle re-arm period
    locked  = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(4);                       // E0
    chk("to_pll_high_e0", pll_resetb, 1);
    tick(31);
    chk("to_pll_high_e31", pll_resetb, 1);
    chk("to_count_e31", timeout_count, 0);
    tick(1);
    chk("to_pll_low_e32", pll_resetb, 0);
    chk("to_count_e32", timeout_count, 1);
    tick(3);
    chk("to_pll_low_e35", pll_resetb, 0);
    tick(1);
    chk("to_pll_high_e36", pll_resetb, 1);
    tick(36 * 254);
    chk("to_count_255", timeout_count, 255);
    chk("to_pll_period", pll_resetb, 1);
    tick(36 * 2);
    chk("to_count_sat", timeout_count, 255);
    chk("to_loss", loss_count, 0);
    chk("to_sys_low", sys_reset_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
